// File: rtl/tx_frame_arbiter_pkg.sv
// Shared TX definitions: frame length defaults, byte counter width and
// the arbiter state encoding.
package tx_frame_arbiter_pkg;

  localparam int unsigned TX_MIN_LEN = 60;
  localparam int unsigned TX_MAX_LEN = 1514;
  localparam int unsigned TX_CNT_W   = 11;

  typedef logic [TX_CNT_W-1:0] tx_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BODY  = 2'd1,
    S_PAD   = 2'd2,
    S_DRAIN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Requester byte streams plus TX FIFO write port for the frame arbiter.
interface tx_frame_arbiter_if;
  import tx_frame_arbiter_pkg::*;

  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       fifo_afull;
  logic       fifo_wren;
  logic [7:0] fifo_din;
  logic       fifo_EOD_in;
  logic [1:0] grant;
  logic       busy;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    output fifo_afull,
    input  req0_ready, req1_ready, fifo_wren, fifo_din, fifo_EOD_in, grant, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    input  fifo_afull,
    output req0_ready, req1_ready, fifo_wren, fifo_din, fifo_EOD_in, grant, busy
  );

endinterface

// File: rtl/tx_frame_arbiter_rr_arb2.sv
// Two-input round-robin picker; the priority pointer moves only when a
// frame completes, so arbitration is frame-granular.
module tx_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       adv_owner1,
  output logic [1:0] pick
);

  // last_q = 1 means requester 1 owned the most recent completed frame
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    pick   = 2'b00;
    if (advance) last_d = adv_owner1;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-level arbiter between two byte requesters feeding one TX FIFO, with
// minimum-length zero padding and maximum-length truncation.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int unsigned MIN_LEN = TX_MIN_LEN,
  parameter int unsigned MAX_LEN = TX_MAX_LEN
) (
  input  logic                clk,
  input  logic                reset,
  tx_frame_arbiter_if.slave   bus
);

  localparam tx_cnt_t MIN_C = tx_cnt_t'(MIN_LEN);
  localparam tx_cnt_t MAX_C = tx_cnt_t'(MAX_LEN);

  tx_state_e  state_q, state_d;
  logic [1:0] grant_q, grant_d;
  tx_cnt_t    cnt_q, cnt_d, cnt_inc;
  logic       wren_q, wren_d;
  logic       eod_q, eod_d;
  logic [7:0] din_q, din_d;

  logic [1:0] pick;
  logic       advance;
  logic       rdy, accept, sel_valid, sel_last;
  logic [7:0] sel_data;

  tx_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({bus.req1_valid, bus.req0_valid}),
    .advance    (advance),
    .adv_owner1 (grant_q[1]),
    .pick       (pick)
  );

  // Drain swallows the overlong tail without writing, so afull is irrelevant there
  always_comb begin
    rdy            = (state_q == S_DRAIN) || ((state_q == S_BODY) && !bus.fifo_afull);
    bus.req0_ready = rdy & grant_q[0];
    bus.req1_ready = rdy & grant_q[1];
    sel_valid      = grant_q[1] ? bus.req1_valid : bus.req0_valid;
    sel_data       = grant_q[1] ? bus.req1_data  : bus.req0_data;
    sel_last       = grant_q[1] ? bus.req1_last  : bus.req0_last;
    accept         = rdy & sel_valid;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    wren_d  = 1'b0;
    eod_d   = 1'b0;
    din_d   = din_q;
    advance = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (pick != 2'b00) begin
          grant_d = pick;
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (accept) begin
          wren_d = 1'b1;
          din_d  = sel_data;
          cnt_d  = cnt_inc;
          if (sel_last) begin
            if (cnt_inc >= MIN_C) begin
              eod_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_PAD;
            end
          end else if (cnt_inc == MAX_C) begin
            eod_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_PAD: begin
        if (!bus.fifo_afull) begin
          wren_d = 1'b1;
          din_d  = '0;
          cnt_d  = cnt_inc;
          if (cnt_inc >= MIN_C) begin
            eod_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (accept && sel_last) state_d = S_IDLE;
      end
    endcase
    // Every return to idle is a frame completion: release grant, rotate priority
    if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
      advance = 1'b1;
      grant_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      eod_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      wren_q  <= wren_d;
      eod_q   <= eod_d;
      din_q   <= din_d;
    end
  end

  assign bus.fifo_wren   = wren_q;
  assign bus.fifo_din    = din_q;
  assign bus.fifo_EOD_in = eod_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized bench for tx_frame_arbiter: per-frame expected FIFO contents are
// built from the requester frames (truncate to MAX, zero-pad to MIN, EOD last).
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
  localparam int unsigned MIN_LEN = 60;
  localparam int unsigned MAX_LEN = 1514;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tx_frame_arbiter_if bus();

  tx_frame_arbiter #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus copies (consumed by drivers) and model copies (consumed by monitor)
  int unsigned d_len[2][$];
  logic [7:0]  d_byte[2][$];
  int unsigned m_len[2][$];
  logic [7:0]  m_byte[2][$];
  int unsigned d_cnt[2];
  bit          d_active[2];
  bit          abort = 1'b0;
  bit          gaps = 1'b1;
  int unsigned af_mode = 0;

  logic [7:0]  exp_q[$];
  int unsigned exp_total = 0, wr_total = 0;
  int unsigned cur_len = 0, cur_own = 0, m_acc = 0, n_data = 0, widx = 0;
  int unsigned own_log[$];
  bit          mon_en = 1'b0;
  bit          idle_req_prev = 1'b0, acc_prev = 1'b0, afull_prev = 1'b0;
  logic [1:0]  pend = 2'b00;
  int unsigned last_own = 1;

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  function automatic logic get_ready(input int r);
    return (r == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic drive_loop(input int r);
    set_req(r, 1'b0, 8'h00, 1'b0);
    forever begin
      @(posedge clk); #1;
      if (!abort && d_len[r].size() != 0) begin
        int unsigned len;
        len = d_len[r].pop_front();
        d_active[r] = 1'b1;
        for (int unsigned i = 0; i < len && !abort; i++) begin
          logic [7:0] b;
          bit acc;
          int unsigned t;
          b = d_byte[r].pop_front();
          acc = 1'b0;
          t = 0;
          if (gaps && $urandom_range(0, 7) == 0) begin
            set_req(r, 1'b0, 8'h00, 1'b0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          set_req(r, 1'b1, b, i == len - 1);
          while (!acc && !abort) begin
            @(negedge clk);
            acc = get_ready(r);
            @(posedge clk); #1;
            if (acc) d_cnt[r]++;
            t++;
            if (t > 20000) begin
              check("accept_timeout", 0, 1);
              abort = 1'b1;
            end
          end
        end
        set_req(r, 1'b0, 8'h00, 1'b0);
        d_active[r] = 1'b0;
      end
    end
  endtask

  initial drive_loop(0);
  initial drive_loop(1);

  initial begin : afull_drv
    int unsigned cyc;
    cyc = 0;
    bus.fifo_afull = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (af_mode)
        1:       if (cyc % 3 == 0) bus.fifo_afull = ~bus.fifo_afull;
        2:       bus.fifo_afull = ($urandom_range(0, 3) == 0);
        default: bus.fifo_afull = 1'b0;
      endcase
    end
  end

  task automatic push_frame(input int r, input int unsigned len);
    int unsigned w;
    for (int unsigned i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      d_byte[r].push_back(b);
      m_byte[r].push_back(b);
    end
    d_len[r].push_back(len);
    m_len[r].push_back(len);
    w = (len < MAX_LEN) ? len : MAX_LEN;
    exp_total += (w < MIN_LEN) ? MIN_LEN : w;
  endtask

  task automatic start_frame(input int unsigned o);
    cur_own = o;
    last_own = o;
    own_log.push_back(o);
    exp_q.delete();
    m_acc = 0;
    widx = 0;
    if (m_len[o].size() == 0) begin
      check("unexpected_frame", 1, 0);
      cur_len = 0;
    end else begin
      cur_len = m_len[o].pop_front();
    end
    n_data = (cur_len < MAX_LEN) ? cur_len : MAX_LEN;
    for (int unsigned i = 0; i < cur_len && m_byte[o].size() != 0; i++) begin
      logic [7:0] b;
      b = m_byte[o].pop_front();
      if (i < n_data) exp_q.push_back(b);
    end
    while (exp_q.size() < MIN_LEN) exp_q.push_back(8'h00);
  endtask

  always @(negedge clk) begin : mon
    logic [1:0]  g;
    logic        own_rdy, oth_rdy, exp_rdy, v0, v1;
    logic [7:0]  e;
    if (mon_en) begin
      g  = bus.grant;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      if (bus.fifo_wren) begin
        check("wr_while_afull", 32'(afull_prev), 0);
        wr_total++;
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("fifo_din", bus.fifo_din, e);
          check("fifo_eod", bus.fifo_EOD_in, 32'(exp_q.size() == 0));
          if (widx < n_data) check("write_latency", 32'(acc_prev), 1);
          widx++;
        end
      end
      if (idle_req_prev) begin
        check("busy_after_req", bus.busy, 1);
        check("grant_pick", g, pend);
        check("prev_frame_done", exp_q.size(), 0);
        start_frame(pend[1] ? 1 : 0);
      end
      check("grant", g, bus.busy ? ((cur_own == 1) ? 2'b10 : 2'b01) : 2'b00);
      exp_rdy = bus.busy && ((!bus.fifo_afull && m_acc < n_data) ||
                             (m_acc >= MAX_LEN && m_acc < cur_len));
      own_rdy = (cur_own == 1) ? bus.req1_ready : bus.req0_ready;
      oth_rdy = (cur_own == 1) ? bus.req0_ready : bus.req1_ready;
      check("ready_owner", own_rdy, exp_rdy);
      check("ready_other", oth_rdy, 0);
      acc_prev = bus.busy && own_rdy && ((cur_own == 1) ? v1 : v0);
      if (acc_prev) m_acc++;
      afull_prev = bus.fifo_afull;
      idle_req_prev = !bus.busy && (v0 || v1);
      if (v0 && v1) pend = (last_own == 1) ? 2'b01 : 2'b10;
      else          pend = {v1, v0};
    end
  end

  task automatic wait_done(input string tag);
    int unsigned t, quiet;
    t = 0;
    quiet = 0;
    while (quiet < 4 && t < 40000) begin
      @(negedge clk);
      t++;
      if (!d_active[0] && !d_active[1] && d_len[0].size() == 0 && d_len[1].size() == 0 &&
          !bus.busy && !bus.fifo_wren) quiet++;
      else quiet = 0;
    end
    check({tag, "_done"}, 32'(quiet >= 4), 1);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_wr_total"}, wr_total, exp_total);
    wr_total = 0;
    exp_total = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"}, bus.fifo_wren, 0);
    check({tag, "_din"}, bus.fifo_din, 0);
    check({tag, "_eod"}, bus.fifo_EOD_in, 0);
    check({tag, "_grant"}, bus.grant, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ready0"}, bus.req0_ready, 0);
    check({tag, "_ready1"}, bus.req1_ready, 0);
  endtask

  function automatic int unsigned owner_at(input int unsigned i);
    return (i < own_log.size()) ? own_log[i] : 9;
  endfunction

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // single req0 frame, no backpressure
    own_log.delete(); d_cnt[0] = 0; d_cnt[1] = 0;
    push_frame(0, 100);
    wait_done("s1");
    check("s1_owner", owner_at(0), 0);
    check("s1_frames", own_log.size(), 1);

    // short req1 frame gets padded
    own_log.delete();
    push_frame(1, 5);
    wait_done("s2");
    check("s2_owner", owner_at(0), 1);

    // both requesters contending: frames alternate
    own_log.delete();
    gaps = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_frame(0, 64);
      push_frame(1, 64);
    end
    wait_done("s3");
    gaps = 1'b1;
    check("s3_frames", own_log.size(), 6);
    for (int unsigned i = 0; i < 6; i++) check("s3_alternate", owner_at(i), i % 2);

    // overlong frame: truncated then drained
    own_log.delete(); d_cnt[0] = 0;
    push_frame(0, 1600);
    wait_done("s4");
    check("s4_accepted", d_cnt[0], 1600);

    // afull toggling every 3 cycles
    af_mode = 1;
    push_frame(0, 60);
    wait_done("s5");
    af_mode = 0;

    // random frames, random backpressure, length boundaries
    af_mode = 2;
    for (int i = 0; i < 6; i++) begin
      push_frame(0, $urandom_range(1, 130));
      push_frame(1, $urandom_range(1, 130));
    end
    push_frame(0, MIN_LEN - 1);
    push_frame(1, MIN_LEN);
    push_frame(0, MIN_LEN + 1);
    push_frame(1, MAX_LEN);
    push_frame(0, MAX_LEN + 1);
    wait_done("s6");
    af_mode = 0;

    // reset in the middle of a req1 frame after req0 completed one
    own_log.delete(); d_cnt[1] = 0;
    push_frame(0, 10);
    wait_done("s7a");
    push_frame(1, 100);
    t = 0;
    while (d_cnt[1] < 30 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("s7_reach_byte30", 32'(d_cnt[1] >= 30), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    abort = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid");
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d_len[r].delete(); d_byte[r].delete(); m_len[r].delete(); m_byte[r].delete();
    end
    exp_q.delete();
    exp_total = 0; wr_total = 0;
    last_own = 1; idle_req_prev = 1'b0; acc_prev = 1'b0; afull_prev = 1'b0;
    own_log.delete();
    abort = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    gaps = 1'b0;
    push_frame(0, 20);
    push_frame(1, 20);
    wait_done("s7b");
    check("s7_first_owner", owner_at(0), 0);
    check("s7_second_owner", owner_at(1), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter MIN_LEN, 60, minimum frame bytes written before EOD (pad target, FCS excluded).
REQ-002 SHALL have parameter MAX_LEN, 1514, maximum frame bytes written; longer frames are truncated.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester byte valid.
REQ-006 SHALL have ports req0_data / req1_data  in  8  requester byte.
REQ-007 SHALL have ports req0_last / req1_last  in  1  byte is the final byte of the requester's frame.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  byte accepted when valid & ready.
REQ-009 SHALL have port fifo_afull  in  1  TX FIFO has at most one free entry.
REQ-010 SHALL have port fifo_wren  out  1  write strobe to TX FIFO.
REQ-011 SHALL have port fifo_din  out  8  byte to TX FIFO.
REQ-012 SHALL have port fifo_EOD_in  out  1  end-of-data flag written alongside fifo_din.
REQ-013 SHALL have ports grant  out  2  one-hot current owner (00 = none), and busy  out  1  frame in progress.

Function
REQ-014 SHALL implement states S_IDLE, S_BODY, S_PAD, S_DRAIN.
REQ-015 S_IDLE: if only one reqN_valid is high, SHALL grant that requester; if both, SHALL grant the one not granted last (round-robin, frame-granular); then go to S_BODY on the next cycle.
REQ-016 Grant SHALL be held until the frame completes; no switching mid-frame.
REQ-017 S_BODY: reqN_ready SHALL be high only for the granted requester and only while ~fifo_afull; ready SHALL depend combinationally only on state, grant and fifo_afull.
REQ-018 Each accepted byte SHALL appear on fifo_din with fifo_wren=1 exactly one cycle after acceptance (registered outputs).
REQ-019 An 11-bit byte counter SHALL count bytes written in the current frame; it clears on entering S_IDLE.
REQ-020 Last accepted with count+1 >= MIN_LEN: that byte SHALL carry fifo_EOD_in=1; go to S_IDLE.
REQ-021 Last accepted with count+1 < MIN_LEN: that byte SHALL carry EOD=0; go to S_PAD.
REQ-022 S_PAD: each cycle with ~fifo_afull SHALL write 0x00; the byte making count = MIN_LEN SHALL carry EOD=1; then go to S_IDLE.
REQ-023 Byte number MAX_LEN accepted without last: it SHALL be written with EOD=1; go to S_DRAIN.
REQ-024 S_DRAIN: granted reqN_ready SHALL be 1 regardless of fifo_afull; accepted bytes SHALL be discarded (no fifo_wren); on accepting last, go to S_IDLE.
REQ-025 Byte MAX_LEN accepted with last SHALL end the frame normally (EOD=1, no drain).
REQ-026 fifo_wren SHALL never assert while fifo_afull was high in the accepting cycle; EOD SHALL be asserted exactly once per frame.
REQ-027 busy SHALL be high in all states except S_IDLE; grant SHALL be 00 in S_IDLE.
REQ-028 Requester valid dropping mid-frame SHALL stall (no write, no timeout); the arbiter waits indefinitely.

Reset
REQ-029 reset SHALL force S_IDLE, grant=00, busy=0, fifo_wren=0, fifo_din=0x00, fifo_EOD_in=0, req*_ready=0, counter=0, last-grant pointer=1 (req0 wins the first tie).
REQ-030 Reset mid-frame SHALL abandon the frame immediately; the TX FIFO shares this reset, so no partial-frame cleanup is performed.

Structure
REQ-031 State encodings, MIN_LEN/MAX_LEN defaults and the counter width SHALL live in the shared TX package/include.
REQ-032 Arbitration SHALL be a sub-module tx_rr_arb2 (2-input round-robin, advance pulse on frame completion).

Verification
REQ-033 req0 sends 100-byte frame, fifo_afull=0 -> 100 writes, 1-cycle latency, EOD on byte 100 only, grant=01.
REQ-034 req1 sends 5 bytes -> 5 data writes then 55 writes of 0x00, EOD on write 60.
REQ-035 Both valid at reset release, each sending 64 bytes repeatedly -> frames alternate req0, req1, req0; no byte interleaving.
REQ-036 req0 sends 1600 bytes -> 1514 writes, EOD on 1514, remaining 86 bytes accepted with no fifo_wren, then S_IDLE.
REQ-037 fifo_afull toggled every 3 cycles during a 60-byte frame -> ready low while afull, no write lost or duplicated, 60 writes total.
REQ-038 reset asserted at byte 30 of a frame -> next cycle all outputs at reset values; a fresh frame afterwards is granted to req0.
